// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared types and constants for the animated sprite source
package sprite_pkg;

    localparam int COORD_W = 11;

    typedef enum logic [1:0] {
        ANIM_STATIC   = 2'b00,
        ANIM_LOOP     = 2'b01,
        ANIM_PINGPONG = 2'b10,
        ANIM_ONESHOT  = 2'b11
    } anim_mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

endpackage

// File: rtl/sprite_frame_ram.sv
// rtl/sprite_frame_ram.sv - simple dual-port sprite RAM, registered read port
module sprite_frame_ram #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr_w,
    input  logic [DATA_WIDTH-1:0] data_w,
    input  logic [ADDR_WIDTH-1:0] addr_r,
    output logic [DATA_WIDTH-1:0] data_r
);

    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    // Read samples the array before this edge's write lands: old data on collision.
    always_ff @(posedge clk) begin
        if (we)
            mem[addr_w] <= data_w;
        data_r <= mem[addr_r];
    end

endmodule

// File: rtl/sprite_anim_src.sv
// rtl/sprite_anim_src.sv - animated sprite source with mirroring and frame sequencer
module sprite_anim_src
    import sprite_pkg::*;
#(
    parameter int             CD         = 12,
    parameter int             H_BITS     = 5,
    parameter int             V_BITS     = 5,
    parameter int             FRAME_BITS = 2,
    parameter logic [CD-1:0]  KEY_COLOR  = '0
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [COORD_W-1:0]                   x,
    input  logic [COORD_W-1:0]                   y,
    input  logic [COORD_W-1:0]                   x0,
    input  logic [COORD_W-1:0]                   y0,
    input  logic                                 we,
    input  logic [FRAME_BITS+V_BITS+H_BITS-1:0]  addr_w,
    input  logic [CD-1:0]                        pixel_in,
    input  logic                                 frame_tick,
    input  logic                                 anim_en,
    input  logic [1:0]                           anim_mode,
    input  logic [7:0]                           div,
    input  logic [FRAME_BITS-1:0]                frame_sel,
    input  logic                                 restart,
    input  logic                                 hflip,
    input  logic                                 vflip,
    output logic [CD-1:0]                        sprite_rgb,
    output logic                                 hit,
    output logic [FRAME_BITS-1:0]                cur_frame,
    output logic                                 done
);

    localparam int ADDR = FRAME_BITS + V_BITS + H_BITS;
    localparam logic [FRAME_BITS-1:0] F_ONE    = FRAME_BITS'(1);
    localparam logic [FRAME_BITS-1:0] F_LAST   = {FRAME_BITS{1'b1}};
    localparam logic [FRAME_BITS-1:0] F_PENULT = F_LAST - F_ONE;

    anim_mode_t mode;
    dir_t       dir;
    logic [7:0] tcnt;

    assign mode = anim_mode_t'(anim_mode);

    logic [COORD_W:0]    xr, yr;
    logic                in_region;
    logic [H_BITS-1:0]   xa;
    logic [V_BITS-1:0]   ya;
    logic [ADDR-1:0]     addr_r;
    logic [CD-1:0]       ram_q;
    logic                in_r;

    // 12-bit wrap makes scan positions left/above the origin look huge, so a
    // single upper-bits-zero test covers both sides of the region.
    assign xr        = {1'b0, x} - {1'b0, x0};
    assign yr        = {1'b0, y} - {1'b0, y0};
    assign in_region = (xr[COORD_W:H_BITS] == '0) && (yr[COORD_W:V_BITS] == '0);
    assign xa        = hflip ? ~xr[H_BITS-1:0] : xr[H_BITS-1:0];
    assign ya        = vflip ? ~yr[V_BITS-1:0] : yr[V_BITS-1:0];
    assign addr_r    = {cur_frame, ya, xa};

    sprite_frame_ram #(
        .ADDR_WIDTH (ADDR),
        .DATA_WIDTH (CD)
    ) u_ram (
        .clk    (clk),
        .we     (we),
        .addr_w (addr_w),
        .data_w (pixel_in),
        .addr_r (addr_r),
        .data_r (ram_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_r       <= 1'b0;
            sprite_rgb <= KEY_COLOR;
            hit        <= 1'b0;
        end else begin
            in_r       <= in_region;
            sprite_rgb <= in_r ? ram_q : KEY_COLOR;
            hit        <= in_r && (ram_q != KEY_COLOR);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_frame <= '0;
            dir       <= DIR_UP;
            tcnt      <= 8'd0;
            done      <= 1'b0;
        end else if (restart) begin
            cur_frame <= frame_sel;
            dir       <= DIR_UP;
            tcnt      <= 8'd0;
            done      <= 1'b0;
        end else if (frame_tick) begin
            if (mode == ANIM_STATIC) begin
                cur_frame <= frame_sel;
                tcnt      <= 8'd0;
            end else if (anim_en) begin
                if (tcnt != div) begin
                    tcnt <= tcnt + 8'd1;
                end else begin
                    tcnt <= 8'd0;
                    case (mode)
                        ANIM_LOOP: cur_frame <= cur_frame + F_ONE;
                        ANIM_PINGPONG: begin
                            // Turn around without repeating the end frame.
                            if (dir == DIR_UP) begin
                                if (cur_frame == F_LAST) begin
                                    dir       <= DIR_DOWN;
                                    cur_frame <= F_PENULT;
                                end else begin
                                    cur_frame <= cur_frame + F_ONE;
                                end
                            end else begin
                                if (cur_frame == '0) begin
                                    dir       <= DIR_UP;
                                    cur_frame <= F_ONE;
                                end else begin
                                    cur_frame <= cur_frame - F_ONE;
                                end
                            end
                        end
                        ANIM_ONESHOT: begin
                            if (cur_frame == F_LAST) begin
                                done <= 1'b1;
                            end else begin
                                cur_frame <= cur_frame + F_ONE;
                                if (cur_frame == F_PENULT)
                                    done <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_sprite_anim_src.sv
// tb/tb_sprite_anim_src.sv - directed self-checking bench for sprite_anim_src
module tb_sprite_anim_src;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] x, y, x0, y0;
    logic        we;
    logic [11:0] addr_w;
    logic [11:0] pixel_in;
    logic        frame_tick, anim_en, restart, hflip, vflip;
    logic [1:0]  anim_mode;
    logic [7:0]  div;
    logic [1:0]  frame_sel;
    logic [11:0] sprite_rgb;
    logic        hit;
    logic [1:0]  cur_frame;
    logic        done;

    int n_checks = 0;
    int n_pass   = 0;

    sprite_anim_src dut (
        .clk        (clk),
        .reset      (reset),
        .x          (x),
        .y          (y),
        .x0         (x0),
        .y0         (y0),
        .we         (we),
        .addr_w     (addr_w),
        .pixel_in   (pixel_in),
        .frame_tick (frame_tick),
        .anim_en    (anim_en),
        .anim_mode  (anim_mode),
        .div        (div),
        .frame_sel  (frame_sel),
        .restart    (restart),
        .hflip      (hflip),
        .vflip      (vflip),
        .sprite_rgb (sprite_rgb),
        .hit        (hit),
        .cur_frame  (cur_frame),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
    endtask

    task automatic do_restart(input logic [1:0] sel);
        frame_sel = sel;
        restart   = 1'b1;
        tick();
        restart   = 1'b0;
    endtask

    task automatic write_px(input logic [11:0] a, input logic [11:0] d);
        we = 1'b1; addr_w = a; pixel_in = d;
        tick();
        we = 1'b0;
    endtask

    task automatic scan(input logic [10:0] sx, input logic [10:0] sy);
        x = sx; y = sy;
        tick();
        tick();
    endtask

    int pp_exp [7] = '{1, 2, 3, 2, 1, 0, 1};

    initial begin
        reset = 1'b1; x = '0; y = '0; x0 = 11'd100; y0 = 11'd50;
        we = 1'b0; addr_w = '0; pixel_in = '0; frame_tick = 1'b0; anim_en = 1'b0;
        restart = 1'b0; hflip = 1'b0; vflip = 1'b0; anim_mode = 2'b00; div = 8'd0;
        frame_sel = 2'd0;
        #2;
        check("rst_rgb", sprite_rgb, 12'h000);
        check("rst_hit", hit, 0);
        check("rst_frame", cur_frame, 0);
        check("rst_done", done, 0);
        tick();
        reset = 1'b0;
        tick();

        write_px({2'd0, 5'd3, 5'd5}, 12'hF00);
        write_px({2'd0, 5'd3, 5'd6}, 12'h000);
        write_px({2'd1, 5'd3, 5'd5}, 12'h0A5);

        scan(11'd99, 11'd53);
        check("left_out_rgb", sprite_rgb, 12'h000);
        check("left_out_hit", hit, 0);
        x = 11'd105;
        tick();
        check("lat1_hit", hit, 0);
        tick();
        check("lat2_rgb", sprite_rgb, 12'hF00);
        check("lat2_hit", hit, 1);
        scan(11'd132, 11'd53);
        check("right_out_rgb", sprite_rgb, 12'h000);
        check("right_out_hit", hit, 0);
        scan(11'd105, 11'd49);
        check("above_out_hit", hit, 0);
        scan(11'd106, 11'd53);
        check("key_px_rgb", sprite_rgb, 12'h000);
        check("key_px_hit", hit, 0);

        hflip = 1'b1;
        scan(11'd126, 11'd53);
        check("hflip_rgb", sprite_rgb, 12'hF00);
        check("hflip_hit", hit, 1);
        hflip = 1'b0; vflip = 1'b1;
        scan(11'd105, 11'd78);
        check("vflip_rgb", sprite_rgb, 12'hF00);
        vflip = 1'b0;

        frame_sel = 2'd1;
        pulse_tick();
        check("static_sel1", cur_frame, 1);
        scan(11'd105, 11'd53);
        check("frame1_rgb", sprite_rgb, 12'h0A5);

        anim_en = 1'b1; anim_mode = 2'b01; div = 8'd2;
        do_restart(2'd0);
        for (int i = 1; i <= 12; i++) begin
            pulse_tick();
            check($sformatf("loop_t%0d", i), cur_frame, (i / 3) % 4);
        end
        anim_en = 1'b0;
        pulse_tick();
        check("freeze", cur_frame, 0);
        anim_en = 1'b1;

        anim_mode = 2'b10; div = 8'd0;
        do_restart(2'd0);
        for (int i = 0; i < 7; i++) begin
            pulse_tick();
            check($sformatf("pp_t%0d", i), cur_frame, pp_exp[i]);
        end

        anim_mode = 2'b11;
        do_restart(2'd0);
        for (int i = 1; i <= 4; i++) begin
            pulse_tick();
            check($sformatf("os_frame%0d", i), cur_frame, (i < 3) ? i : 3);
            check($sformatf("os_done%0d", i), done, (i >= 3) ? 1 : 0);
        end
        frame_sel = 2'd1; restart = 1'b1; frame_tick = 1'b1;
        tick();
        restart = 1'b0; frame_tick = 1'b0;
        check("restart_frame", cur_frame, 1);
        check("restart_done", done, 0);

        anim_mode = 2'b01;
        do_restart(2'd0);
        pulse_tick();
        pulse_tick();
        check("pre_rst_frame", cur_frame, 2);
        write_px({2'd2, 5'd3, 5'd5}, 12'h5A5);
        scan(11'd105, 11'd53);
        check("pre_rst_rgb", sprite_rgb, 12'h5A5);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_frame", cur_frame, 0);
        check("async_rst_rgb", sprite_rgb, 12'h000);
        check("async_rst_hit", hit, 0);
        tick();
        reset = 1'b0;
        anim_mode = 2'b00; frame_sel = 2'd3;
        tick();
        check("static_hold", cur_frame, 0);
        pulse_tick();
        check("static_sel3", cur_frame, 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sprite_anim_src.md
# sprite_anim_src

Parametrised animated sprite source for the video pipeline: one sprite of 2^H_BITS × 2^V_BITS pixels with up to 2^FRAME_BITS animation frames held in an on-chip dual-port sprite RAM. Compares the scan position (x, y) against the sprite origin (x0, y0) and emits the sprite pixel, or the chroma key colour outside the sprite. Provides horizontal/vertical mirroring and a frame-rate animation sequencer (loop, ping-pong, one-shot). Sits in parallel with the other sprite sources ahead of the chroma-key blender.

## Interface
Parameters:
- CD, 12, colour depth in bits
- H_BITS, 5, log2 of sprite width (H_SIZE = 2^H_BITS)
- V_BITS, 5, log2 of sprite height (V_SIZE = 2^V_BITS)
- FRAME_BITS, 2, log2 of animation frame count (NF = 2^FRAME_BITS, NF ≥ 2)
- KEY_COLOR, 0, chroma key value, CD bits

Ports (ADDR = FRAME_BITS+V_BITS+H_BITS):
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- x, y  in  11 each  current scan coordinate
- x0, y0  in  11 each  sprite origin (top-left)
- we  in  1  sprite RAM write enable
- addr_w  in  ADDR  write address {frame, row, col}
- pixel_in  in  CD  write data
- frame_tick  in  1  one-cycle pulse per video frame (start of vertical blank)
- anim_en  in  1  sequencer enable; low freezes sequencer state
- anim_mode  in  2  00 static, 01 loop, 10 ping-pong, 11 one-shot
- div  in  8  frame_ticks per animation step minus one
- frame_sel  in  FRAME_BITS  static frame / restart frame
- restart  in  1  one-cycle pulse, reloads sequencer
- hflip, vflip  in  1 each  mirror horizontally / vertically
- sprite_rgb  out  CD  pixel output
- hit  out  1  in-region and pixel ≠ KEY_COLOR, aligned with sprite_rgb
- cur_frame  out  FRAME_BITS  frame currently displayed
- done  out  1  one-shot sequence has reached last frame

## Operation
- Relative coordinates: xr = {0,x} − {0,x0}, yr = {0,y} − {0,y0}, 12-bit signed. in_region = 0 ≤ xr < H_SIZE and 0 ≤ yr < V_SIZE.
- Column index xa = hflip ? ~xr[H_BITS-1:0] : xr[H_BITS-1:0]; row index ya likewise with vflip/yr. Read address = {cur_frame, ya, xa}.
- Sequencer state: cur_frame, dir (up/down), tick counter tcnt (8 bit), done.
- Step condition: frame_tick && anim_en && mode ≠ static && tcnt == div; on step tcnt ← 0; on a non-step qualifying tick tcnt ← tcnt+1. div = 0 steps every tick.
- Static: on each frame_tick, cur_frame ← frame_sel (ignores anim_en, tcnt held at 0).
- Loop: step → cur_frame+1, wraps NF−1 → 0.
- Ping-pong: up: at NF−1 step sets dir ← down and cur_frame ← NF−2, else +1; down: at 0 sets dir ← up and cur_frame ← 1, else −1. No frame shown twice at the turn.
- One-shot: step → +1; entering NF−1 sets done ← 1; further steps hold NF−1 and done.
- restart: cur_frame ← frame_sel, dir ← up, tcnt ← 0, done ← 0; wins over a simultaneous frame_tick.
- Changing anim_mode takes effect at the next frame_tick; dir/done cleared only by restart or reset.
- Writes via we/addr_w are independent of reading; same-address write-during-read returns old data.

## Timing
- Reset values: sprite_rgb = KEY_COLOR, hit = 0, cur_frame = 0, done = 0; internal dir = up, tcnt = 0. Reset mid-frame takes effect immediately (asynchronous).
- Pixel latency: 2 clocks from x, y, x0, y0, hflip, vflip to sprite_rgb/hit. Stage 1: synchronous RAM read plus registered in_region; stage 2: key multiplex and hit registered.
- Sequencer registers update on the clock edge where frame_tick/restart is sampled; new cur_frame used by the read address in the next cycle.
- Written pixel visible on read no earlier than one clock after the write.

## Structure
- Package sprite_pkg: anim_mode enum (ANIM_STATIC, ANIM_LOOP, ANIM_PINGPONG, ANIM_ONESHOT), dir enum, coordinate width constant (11).
- Sub-module sprite_frame_ram: simple dual-port RAM, parameters ADDR_WIDTH/DATA_WIDTH, one write port, one registered read port.
- Sequencer is an always_ff block in the top; no further sub-modules.

## Test plan
- Region/latency: write frame 0 pixel (row 3, col 5) = 0xF00, x0=100, y0=50; scan x=105, y=53 -> sprite_rgb = 0xF00, hit = 1 exactly 2 clocks later; x=99 or x=132 -> KEY_COLOR, hit = 0.
- Mirroring: same pixel, hflip=1 -> 0xF00 at x=126 (col 26); vflip=1 -> at y=78 (row 28).
- Loop: mode 01, div=2, NF=4 -> cur_frame advances every 3rd frame_tick: 0,1,2,3,0.
- Ping-pong: mode 10, div=0 -> cur_frame per tick 1,2,3,2,1,0,1.
- One-shot/restart: mode 11, div=0 -> 1,2,3 then done=1 holding 3; restart with frame_sel=1 in same cycle as frame_tick -> cur_frame=1, done=0.
- Reset mid-animation: assert reset during running loop at cur_frame=2 -> cur_frame=0, sprite_rgb=KEY_COLOR, hit=0 without a clock edge; static mode with frame_sel=3 -> cur_frame=3 after next frame_tick.
